// File: rtl/seq_det_pkg.sv
// Shared constants for the configurable serial pattern detector:
// FSM state encoding and power-on configuration defaults.
package seq_det_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [31:0] CFG_PAT_RST = 32'hD;
  localparam int          CFG_LEN_RST = 4;
  localparam logic        CFG_OVL_RST = 1'b1;
  localparam int          CFG_THR_RST = 1;

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked comparator
// producing the Mealy match for a 1..MAX_LEN bit pattern.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr_hist,
  input  logic               i_clr_fill,
  input  logic               i_shift,
  input  logic               i_din,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  input  logic               i_overlap,
  output logic               o_match
);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;

  logic [MAX_LEN-1:0] w_win;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_n;
  logic               w_hit;

  always_comb begin
    w_win    = {r_hist[MAX_LEN-2:0], i_din};
    w_fill_n = (r_fill == LEN_W'(MAX_LEN)) ? r_fill
                                           : r_fill + LEN_W'(1);
    w_mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < i_len);
    end
    // fill guards against stale history after arm/clear
    w_hit   = (w_fill_n >= i_len) &&
              (((w_win ^ i_pattern) & w_mask) == '0);
    o_match = i_shift && w_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      if (i_clr_hist) begin
        r_hist <= '0;
      end else if (i_shift) begin
        r_hist <= w_win;
      end
      if (i_clr_fill) begin
        r_fill <= '0;
      end else if (i_shift) begin
        r_fill <= (o_match && !i_overlap) ? '0 : w_fill_n;
      end
    end
  end

endmodule

// File: rtl/seq_detect_controller.sv
// Run-time controller: arm/stop/clear FSM, config registers,
// saturating match counter and threshold completion.
module seq_detect_controller
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_threshold,
  input  logic               din,
  input  logic               din_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  logic [1:0]         r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [CNT_W-1:0]   r_thr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic [1:0]         w_nxt;
  logic               w_armed;
  logic               w_rest;
  logic               w_arm;
  logic               w_shift;
  logic               w_match;
  logic               w_sat;
  logic [CNT_W:0]     w_cnt_inc;
  logic               w_thr_hit;
  logic               w_len_ok;
  logic               w_cfg_wr;
  logic               w_cfg_bad;

  assign w_armed   = (r_state == ST_ARMED);
  assign w_rest    = (r_state == ST_IDLE) ||
                     (r_state == ST_DONE);
  assign w_arm     = start && !stop && !clear && w_rest;
  // a bit arriving with stop/clear is dropped with the disarm
  assign w_shift   = w_armed && din_valid && !clear &&
                     !stop && !reset;
  assign w_sat     = &r_cnt;
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_thr_hit = w_match && !w_sat && (r_thr != '0) &&
                     (w_cnt_inc == {1'b0, r_thr});
  assign w_len_ok  = (cfg_len != '0) &&
                     (cfg_len <= LEN_W'(MAX_LEN));
  assign w_cfg_wr  = cfg_we && w_rest && w_len_ok;
  assign w_cfg_bad = cfg_we && !w_cfg_wr;

  seq_match_core #(.MAX_LEN(MAX_LEN)) u_core (
    .clk        (clk),
    .reset      (reset),
    .i_clr_hist (clear),
    .i_clr_fill (clear || w_arm),
    .i_shift    (w_shift),
    .i_din      (din),
    .i_pattern  (r_pat),
    .i_len      (r_len),
    .i_overlap  (r_ovl),
    .o_match    (w_match)
  );

  always_comb begin
    w_nxt = r_state;
    if (clear) begin
      w_nxt = ST_IDLE;
    end else begin
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (w_arm) w_nxt = ST_ARMED;
        end
        w_armed: begin
          if (stop)           w_nxt = ST_IDLE;
          else if (w_thr_hit) w_nxt = ST_DONE;
        end
        (r_state == ST_DONE): begin
          if (stop)       w_nxt = ST_IDLE;
          else if (w_arm) w_nxt = ST_ARMED;
        end
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt == ST_ARMED);
      r_done  <= (w_nxt == ST_DONE);
      r_err   <= w_cfg_bad;
      if (clear || w_arm) begin
        r_cnt <= '0;
      end else if (w_match && !w_sat) begin
        r_cnt <= w_cnt_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat <= MAX_LEN'(CFG_PAT_RST);
      r_len <= LEN_W'(CFG_LEN_RST);
      r_ovl <= CFG_OVL_RST;
      r_thr <= CNT_W'(CFG_THR_RST);
    end else if (w_cfg_wr) begin
      r_pat <= cfg_pattern;
      r_len <= cfg_len;
      r_ovl <= cfg_overlap;
      r_thr <= cfg_threshold;
    end
  end

  assign match       = w_match;
  assign match_count = r_cnt;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cfg_err     = r_err;

endmodule
